sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Round-robin arbiter that shares one single-port, registered-address sprite ROM (16 rows × 32 columns, 12-bit RGB) among up to NUM_REQ pixel requesters, e.g. the start-screen text renderer, the menu highlight and the attract-mode overlay. It grants one ROM lookup per clock, tracks each in-flight lookup through the ROM latency, and returns the colour tagged with the requester ID. It also flags key-colour (background) pixels as transparent.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ROW_W, 4, ROM row address width
- COL_W, 5, ROM column address width
- COLOR_W, 12, colour width (4:4:4)
- ROM_LAT, 1, clocks from ROM address to valid ROM data
- MAX_BURST, 32, maximum consecutive grants to one holding requester

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req  in  NUM_REQ  per-requester lookup request
- hold  in  NUM_REQ  requester asks to keep the port after this grant
- req_row  in  NUM_REQ*ROW_W  packed row addresses, requester i at slice i
- req_col  in  NUM_REQ*COL_W  packed column addresses
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accept
- rom_row  out  ROW_W  address to ROM
- rom_col  out  COL_W  address to ROM
- rom_color  in  COLOR_W  ROM data, ROM_LAT clocks after address
- rsp_valid  out  1  registered response strobe
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response
- rsp_color  out  COLOR_W  returned colour
- rsp_opaque  out  1  1 when rsp_color != KEY_COLOR

## Operation
- Priority pointer ptr, range 0..NUM_REQ-1, reset value 0. The winner is the first asserted req scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
- gnt is set to the one-hot winner. rom_row and rom_col take the winner's slices. With no req, gnt=0 and the ROM address is 0.
- A requester holds req, row and col stable until it sees gnt. It deasserts req in the following cycle unless it wants another lookup.
- Pointer update on a grant to i:
  - if hold[i]=1 and burst_cnt < MAX_BURST-1, ptr stays at i and burst_cnt increments;
  - otherwise ptr = (i+1) mod NUM_REQ and burst_cnt = 0.
- burst_cnt also clears when the granted requester differs from the previous one, or on an idle cycle.
- In-flight tracking: a shift register of depth ROM_LAT carries {valid, id}. When the stage-ROM_LAT entry is valid, the output register loads rsp_color=rom_color, rsp_id=id, rsp_opaque=(rom_color != KEY_COLOR) and rsp_valid=1. Otherwise rsp_valid=0, and the other rsp fields hold their previous values.
- Async reset mid-operation clears ptr, burst_cnt, the shift register and all rsp outputs to 0. In-flight lookups are dropped and no response is ever produced for them. gnt is 0 while rst_n=0.

## Timing
- Grant: 0 cycles, combinational from req, hold and ptr.
- Response: rsp_valid rises exactly ROM_LAT+1 clocks after the grant cycle (2 clocks at default).
- Throughput: one lookup per clock, back-to-back. Responses return in grant order and are never coalesced.
- Simultaneous requests: exactly one gnt bit per cycle. A requester waits at most (NUM_REQ-1)*MAX_BURST cycles.
- A req that arrives in the same cycle as another requester's burst-limit rotation competes with the new ptr.
- Reset values: rsp_valid=0, rsp_id=0, rsp_color=0, rsp_opaque=0, internal ptr=0.

## Structure
- Shared package sprite_pkg holds:
  - ROW_W, COL_W, COLOR_W;
  - KEY_COLOR = 12'hFFF (white background, drawn transparent);
  - the requester ID constants REQ_START_TXT=0, REQ_MENU=1, REQ_OVERLAY=2, REQ_SPARE=3.
- One sub-module, rr_pick: purely combinational. It takes req and ptr and returns the one-hot winner and its index. The arbiter instantiates it once.
- Target size is 150–250 lines of RTL.

## Test plan
- Single requester: req[0]=1 at row=3, col=4 for one cycle → gnt=0001 same cycle; 2 clocks later rsp_valid=1, rsp_id=0, rsp_color equals the ROM word at {3,4}, rsp_opaque matches the colour against 12'hFFF.
- All four requesting continuously with hold=0 → grants rotate 0,1,2,3,0,…, one per cycle; rsp_id follows the same sequence with 2-cycle lag and no gaps.
- Requester 1 holds hold=1 with req=1111 → 32 consecutive grants to 1, then a grant to 2; burst_cnt is back at 0 afterwards.
- Key-colour pixel (ROM word 12'hFFF) → rsp_opaque=0; a 12'h000 pixel → rsp_opaque=1.
- rst_n pulsed low for one cycle while two lookups are in flight → no rsp_valid afterwards; the next grant goes to the lowest-indexed active requester (ptr=0).
- No requests for 10 cycles, then req=0100 → gnt=0100 immediately; rsp_valid stays 0 throughout the idle period.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite ROM arbiter: ROM geometry, the transparent key
// colour and the requester ID assignments.
package sprite_pkg;

  localparam int ROW_W   = 4;
  localparam int COL_W   = 5;
  localparam int COLOR_W = 12;

  // White background pixels are drawn transparent.
  localparam logic [COLOR_W-1:0] KEY_COLOR = 12'hFFF;

  localparam int REQ_START_TXT = 0;
  localparam int REQ_MENU      = 1;
  localparam int REQ_OVERLAY   = 2;
  localparam int REQ_SPARE     = 3;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request at or after the
// priority pointer, wrapping modulo NUM_REQ, as a one-hot vector plus index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_valid       = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-address sprite ROM among NUM_REQ
// requesters; returns each lookup's colour tagged with its requester ID.
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROW_W     = sprite_pkg::ROW_W,
  parameter int COL_W     = sprite_pkg::COL_W,
  parameter int COLOR_W   = sprite_pkg::COLOR_W,
  parameter int ROM_LAT   = 1,
  parameter int MAX_BURST = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         hold,
  input  logic [NUM_REQ*ROW_W-1:0]   req_row,
  input  logic [NUM_REQ*COL_W-1:0]   req_col,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ROW_W-1:0]           rom_row,
  output logic [COL_W-1:0]           rom_col,
  input  logic [COLOR_W-1:0]         rom_color,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [COLOR_W-1:0]         rsp_color,
  output logic                       rsp_opaque
);
  import sprite_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [COLOR_W-1:0] KEY_C = COLOR_W'(KEY_COLOR);

  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [ROM_LAT-1:0] r_pipe_vld;
  logic [IDX_W-1:0]   r_pipe_id [ROM_LAT];

  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;
  logic               w_grant_vld;
  logic [CNT_W-1:0]   w_cnt_eff;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [ROW_W-1:0]   w_rows [NUM_REQ];
  logic [COL_W-1:0]   w_cols [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  // No grant may escape while reset is asserted.
  assign w_grant_vld = w_pick_vld & rst_n;
  assign gnt         = w_grant_vld ? w_pick_gnt : '0;

  // Unpack per-requester addresses and steer the winner's onto the ROM port.
  always_comb begin
    rom_row = '0;
    rom_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rows[i] = req_row[i*ROW_W +: ROW_W];
      w_cols[i] = req_col[i*COL_W +: COL_W];
    end
    if (w_grant_vld) begin
      rom_row = w_rows[w_pick_idx];
      rom_col = w_cols[w_pick_idx];
    end else begin
      rom_row = '0;
      rom_col = '0;
    end
  end

  // A nonzero count implies the previous grant went to ptr, so a different winner restarts it.
  assign w_cnt_eff = (w_pick_idx == r_ptr) ? r_burst_cnt : '0;

  // Pointer and burst counter next-state.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = '0;
    if (w_grant_vld) begin
      if (hold[w_pick_idx] && (w_cnt_eff < CNT_W'(MAX_BURST - 1))) begin
        w_ptr_nxt = w_pick_idx;
        w_cnt_nxt = w_cnt_eff + CNT_W'(1);
      end else begin
        w_ptr_nxt = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);
        w_cnt_nxt = '0;
      end
    end else begin
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = '0;
    end
  end

  // Priority pointer and burst counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  // In-flight lookup tags, aligned with the ROM data latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int s = 0; s < ROM_LAT; s++) r_pipe_id[s] <= '0;
    end else begin
      r_pipe_vld[0] <= w_grant_vld;
      r_pipe_id[0]  <= w_pick_idx;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_id[s]  <= r_pipe_id[s-1];
      end
    end
  end

  // Response register; fields other than the strobe hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_color  <= '0;
      rsp_opaque <= 1'b0;
    end else if (r_pipe_vld[ROM_LAT-1]) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= r_pipe_id[ROM_LAT-1];
      rsp_color  <= rom_color;
      rsp_opaque <= (rom_color != KEY_C);
    end else begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed grant checks at issue time,
// responses checked by an independent monitor against queued expectations.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [3:0]  hold = 4'd0;
  logic [15:0] req_row;
  logic [19:0] req_col;
  logic [3:0]  gnt;
  logic [3:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_color = 12'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_color;
  logic        rsp_opaque;

  logic [3:0] rows [4];
  logic [4:0] cols [4];

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [11:0] color;
    logic       opaque;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_rom_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .hold       (hold),
    .req_row    (req_row),
    .req_col    (req_col),
    .gnt        (gnt),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_color  (rom_color),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_color  (rsp_color),
    .rsp_opaque (rsp_opaque)
  );

  always_comb begin
    req_row = '0;
    req_col = '0;
    for (int i = 0; i < 4; i++) begin
      req_row[i*4 +: 4] = rows[i];
      req_col[i*5 +: 5] = cols[i];
    end
  end

  // ROM contents: {row, col, 3'b101}, with one key-colour and one black pixel.
  function automatic logic [11:0] rom_word(input logic [3:0] r, input logic [4:0] c);
    if (r == 4'd5 && c == 5'd7) return 12'hFFF;
    if (r == 4'd6 && c == 5'd8) return 12'h000;
    return {r, c, 3'b101};
  endfunction

  always @(posedge clk) rom_color <= rom_word(rom_row, rom_col);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the expectation due this cycle and compare the response.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
      check("rsp_color", {20'd0, rsp_color}, {20'd0, e.color});
      check("rsp_opaque", {31'd0, rsp_opaque}, {31'd0, e.opaque});
    end else if (rst_n && rsp_valid) begin
      check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      check("missing_rsp", 32'd0, 32'd1);
    end
  end

  // Drive one cycle of requests, check the grant and queue the expected response.
  task automatic step(input logic [3:0] r, input logic [3:0] h, input logic [3:0] exp_gnt,
                      input string name);
    int id;
    logic [11:0] col;
    req  = r;
    hold = h;
    #1;
    check(name, {28'd0, gnt}, {28'd0, exp_gnt});
    if (exp_gnt != 4'd0) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (exp_gnt[i]) id = i;
      col = rom_word(rows[id], cols[id]);
      sb.push_back('{cyc + 2, 2'(id), col, (col != 12'hFFF)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rows[0] = 4'd3; cols[0] = 5'd4;
    rows[1] = 4'd2; cols[1] = 5'd9;
    rows[2] = 4'd5; cols[2] = 5'd7;
    rows[3] = 4'd6; cols[3] = 5'd8;

    // Reset state, including grant suppression during reset.
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", {28'd0, gnt}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_color", {20'd0, rsp_color}, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single lookup at row 3, col 4 -> 12'h325, opaque.
    step(4'b0001, 4'b0000, 4'b0001, "single_gnt");
    repeat (3) step(4'b0000, 4'b0000, 4'b0000, "idle_after_single");

    // Rotation from ptr=1; requesters 2 and 3 hit the key and black pixels.
    for (int k = 0; k < 8; k++)
      step(4'b1111, 4'b0000, 4'b0001 << ((1 + k) % 4), "rotate_gnt");

    // Requester 1 bursts for exactly MAX_BURST grants, then rotates; twice.
    for (int k = 0; k < 32; k++) step(4'b1111, 4'b0010, 4'b0010, "burst1_gnt");
    step(4'b1111, 4'b0010, 4'b0100, "burst1_end_gnt");
    step(4'b1111, 4'b0010, 4'b1000, "after_burst_gnt3");
    step(4'b1111, 4'b0010, 4'b0001, "after_burst_gnt0");
    for (int k = 0; k < 32; k++) step(4'b1111, 4'b0010, 4'b0010, "burst2_gnt");
    step(4'b1111, 4'b0010, 4'b0100, "burst2_end_gnt");

    // Idle stretch, then a lone request is granted immediately.
    for (int k = 0; k < 10; k++) step(4'b0000, 4'b0000, 4'b0000, "idle_gnt");
    step(4'b0100, 4'b0000, 4'b0100, "wake_gnt");

    // Two lookups in flight (ptr left at 3), then an asynchronous reset pulse.
    step(4'b0010, 4'b0000, 4'b0010, "pre_reset_gnt1");
    step(4'b0100, 4'b0000, 4'b0100, "pre_reset_gnt2");
    rst_n = 1'b0;
    sb.delete();
    req = 4'b1111;
    #1;
    check("midreset_gnt", {28'd0, gnt}, 32'd0);
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_rsp_id", {30'd0, rsp_id}, 32'd0);
    check("midreset_rsp_color", {20'd0, rsp_color}, 32'd0);
    check("midreset_rsp_opaque", {31'd0, rsp_opaque}, 32'd0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1010, 4'b0000, 4'b0010, "post_reset_ptr0_gnt");
    for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, 4'b0000, "drain_gnt");
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
